// File: rtl/datamover_pkg.sv
// Shared constants, state encodings and helpers for the datamover AXI3 HP-port DMA.
// Pure definitions: no logic, no latency.
package datamover_pkg;

    localparam int         BEAT_BYTES  = 8;
    localparam int         BOUNDARY_4K = 4096;
    localparam int         PAGE_BEATS  = BOUNDARY_4K / BEAT_BYTES;
    localparam logic [2:0] AXSIZE_64   = 3'b011;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] AXPROT_0    = 3'b000;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_ACK,
        WR_AW,
        WR_W,
        WR_B,
        WR_DONE
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACK,
        RD_AR,
        RD_R
    } rd_state_t;

    // Byte length to 64-bit beat count, rounding a partial final word up.
    function automatic logic [20:0] len_to_beats(input logic [22:0] len);
        logic [23:0] t;
        t = {1'b0, len} + 24'd7;
        return t[23:3];
    endfunction

endpackage

// File: rtl/dm_burst_calc.sv
// Burst sizer: beats = min(remaining, MAX_BURST, beats left in the current 4 KB page).
// Purely combinational, zero latency; no handshake.
module dm_burst_calc
    import datamover_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [8:0]  page_beat_i,
    input  logic [20:0] remaining_i,
    output logic [4:0]  burst_o
);

    localparam logic [9:0] PAGE_BEATS_W = 10'(PAGE_BEATS);
    localparam logic [9:0] MAX_BURST_W  = 10'(MAX_BURST);

    logic [9:0] to_boundary;
    logic [4:0] cap;

    assign to_boundary = PAGE_BEATS_W - {1'b0, page_beat_i};
    assign cap         = (to_boundary < MAX_BURST_W) ? to_boundary[4:0] : 5'(MAX_BURST);
    assign burst_o     = (remaining_i < {16'd0, cap}) ? remaining_i[4:0] : cap;

endmodule

// File: rtl/datamover_controller.sv
// Command-driven S2MM/MM2S DMA onto a 64-bit AXI3 HP port; the read path exists only with DATAMOVER_RD_PATH_EN.
// Ack one cycle after req; stream sides stall directly on wready/rready; one command per direction.
module datamover_controller
    import datamover_pkg::*;
#(
    parameter logic [3:0] AXI_ID    = 4'd0,
    parameter logic [3:0] AXI_CACHE = 4'b0011,
    parameter int         MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_s2mm_wr_cmd_addr,
    input  logic [22:0] i_s2mm_wr_cmd_length,
    input  logic        i_wr_cmd_req,
    output logic        o_wr_cmd_ack,
    input  logic        i_wr_valid,
    input  logic [63:0] i_wr_data,
    output logic        o_wr_ready,
    output logic        o_write_finish,
    input  logic [54:0] i_rd_cmd_data,
    input  logic        i_rd_cmd_req,
    output logic        o_rd_cmd_ack,
    input  logic        i_rd_ready,
    output logic        o_rd_valid,
    output logic        o_rd_last,
    output logic [63:0] o_rd_data,
    input  logic        hp0_awready,
    output logic        hp0_awvalid,
    output logic [3:0]  hp0_awid,
    output logic [31:0] hp0_awaddr,
    output logic [3:0]  hp0_awlen,
    output logic [2:0]  hp0_awsize,
    output logic [1:0]  hp0_awburst,
    output logic [2:0]  hp0_awprot,
    output logic [3:0]  hp0_awcache,
    output logic [63:0] hp0_wdata,
    output logic [7:0]  hp0_wstrb,
    output logic        hp0_wlast,
    output logic        hp0_wvalid,
    input  logic        hp0_wready,
    input  logic [1:0]  hp0_bresp,
    input  logic        hp0_bvalid,
    output logic        hp0_bready,
    input  logic        hp0_arready,
    output logic        hp0_arvalid,
    output logic [3:0]  hp0_arid,
    output logic [31:0] hp0_araddr,
    output logic [3:0]  hp0_arlen,
    output logic [2:0]  hp0_arsize,
    output logic [1:0]  hp0_arburst,
    output logic [2:0]  hp0_arprot,
    output logic [3:0]  hp0_arcache,
    input  logic [63:0] hp0_rdata,
    input  logic [1:0]  hp0_rresp,
    input  logic        hp0_rlast,
    input  logic        hp0_rvalid,
    output logic        hp0_rready
);

    wr_state_t   wr_state_q, wr_state_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [20:0] wr_rem_q, wr_rem_d;
    logic [2:0]  wr_tail_q, wr_tail_d;
    logic [4:0]  wr_burst_q, wr_burst_d;
    logic [4:0]  wr_cnt_q, wr_cnt_d;
    logic [4:0]  wr_calc;
    logic        wr_final_burst;

    // bresp is deliberately ignored: an error response still completes the command.
    logic unused_wr;
    assign unused_wr = ^{hp0_bresp, i_s2mm_wr_cmd_addr[2:0]};

    dm_burst_calc #(.MAX_BURST(MAX_BURST)) u_wr_calc (
        .page_beat_i (wr_addr_q[11:3]),
        .remaining_i (wr_rem_q),
        .burst_o     (wr_calc)
    );

    assign wr_final_burst = (wr_rem_q == {16'd0, wr_burst_q});

    assign hp0_awid    = AXI_ID;
    assign hp0_awaddr  = wr_addr_q;
    assign hp0_awsize  = AXSIZE_64;
    assign hp0_awburst = BURST_INCR;
    assign hp0_awprot  = AXPROT_0;
    assign hp0_awcache = AXI_CACHE;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            wr_addr_q  <= '0;
            wr_rem_q   <= '0;
            wr_tail_q  <= '0;
            wr_burst_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_rem_q   <= wr_rem_d;
            wr_tail_q  <= wr_tail_d;
            wr_burst_q <= wr_burst_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    always_comb begin
        wr_state_d     = wr_state_q;
        wr_addr_d      = wr_addr_q;
        wr_rem_d       = wr_rem_q;
        wr_tail_d      = wr_tail_q;
        wr_burst_d     = wr_burst_q;
        wr_cnt_d       = wr_cnt_q;
        o_wr_cmd_ack   = 1'b0;
        o_write_finish = 1'b0;
        o_wr_ready     = 1'b0;
        hp0_awvalid    = 1'b0;
        hp0_awlen      = 4'd0;
        hp0_wvalid     = 1'b0;
        hp0_wdata      = '0;
        hp0_wlast      = 1'b0;
        hp0_wstrb      = 8'hFF;
        hp0_bready     = 1'b0;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (i_wr_cmd_req) begin
                    wr_addr_d  = {i_s2mm_wr_cmd_addr[31:3], 3'b000};
                    wr_rem_d   = len_to_beats(i_s2mm_wr_cmd_length);
                    wr_tail_d  = i_s2mm_wr_cmd_length[2:0];
                    wr_state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                o_wr_cmd_ack = 1'b1;
                wr_state_d   = (wr_rem_q == '0) ? WR_DONE : WR_AW;
            end
            WR_AW: begin
                hp0_awvalid = 1'b1;
                hp0_awlen   = 4'(wr_calc - 5'd1);
                if (hp0_awready) begin
                    wr_burst_d = wr_calc;
                    wr_cnt_d   = '0;
                    wr_state_d = WR_W;
                end
            end
            WR_W: begin
                hp0_wvalid = i_wr_valid;
                o_wr_ready = hp0_wready;
                hp0_wdata  = i_wr_data;
                hp0_wlast  = (wr_cnt_q == wr_burst_q - 5'd1);
                // Only the very last word of the command carries a partial strobe.
                if (hp0_wlast && wr_final_burst && wr_tail_q != 3'd0) begin
                    hp0_wstrb = ~(8'hFF << wr_tail_q);
                end
                if (i_wr_valid && hp0_wready) begin
                    wr_cnt_d = wr_cnt_q + 5'd1;
                    if (hp0_wlast) begin
                        wr_addr_d  = wr_addr_q + {24'd0, wr_burst_q, 3'b000};
                        wr_rem_d   = wr_rem_q - {16'd0, wr_burst_q};
                        wr_state_d = WR_B;
                    end
                end
            end
            WR_B: begin
                hp0_bready = 1'b1;
                if (hp0_bvalid) begin
                    wr_state_d = (wr_rem_q == '0) ? WR_DONE : WR_AW;
                end
            end
            WR_DONE: begin
                o_write_finish = 1'b1;
                wr_state_d     = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

`ifdef DATAMOVER_RD_PATH_EN
    rd_state_t   rd_state_q, rd_state_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [20:0] rd_rem_q, rd_rem_d;
    logic [4:0]  rd_burst_q, rd_burst_d;
    logic [4:0]  rd_calc;
    logic        rd_final_burst;

    logic unused_rd;
    assign unused_rd = ^{hp0_rresp, i_rd_cmd_data[2:0]};

    dm_burst_calc #(.MAX_BURST(MAX_BURST)) u_rd_calc (
        .page_beat_i (rd_addr_q[11:3]),
        .remaining_i (rd_rem_q),
        .burst_o     (rd_calc)
    );

    assign rd_final_burst = (rd_rem_q == {16'd0, rd_burst_q});

    assign hp0_arid    = AXI_ID;
    assign hp0_araddr  = rd_addr_q;
    assign hp0_arsize  = AXSIZE_64;
    assign hp0_arburst = BURST_INCR;
    assign hp0_arprot  = AXPROT_0;
    assign hp0_arcache = AXI_CACHE;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_rem_q   <= '0;
            rd_burst_q <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_rem_q   <= rd_rem_d;
            rd_burst_q <= rd_burst_d;
        end
    end

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_addr_d    = rd_addr_q;
        rd_rem_d     = rd_rem_q;
        rd_burst_d   = rd_burst_q;
        o_rd_cmd_ack = 1'b0;
        o_rd_valid   = 1'b0;
        o_rd_last    = 1'b0;
        o_rd_data    = '0;
        hp0_arvalid  = 1'b0;
        hp0_arlen    = 4'd0;
        hp0_rready   = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (i_rd_cmd_req) begin
                    rd_addr_d  = {i_rd_cmd_data[31:3], 3'b000};
                    rd_rem_d   = len_to_beats(i_rd_cmd_data[54:32]);
                    rd_state_d = RD_ACK;
                end
            end
            RD_ACK: begin
                o_rd_cmd_ack = 1'b1;
                rd_state_d   = (rd_rem_q == '0) ? RD_IDLE : RD_AR;
            end
            RD_AR: begin
                hp0_arvalid = 1'b1;
                hp0_arlen   = 4'(rd_calc - 5'd1);
                if (hp0_arready) begin
                    rd_burst_d = rd_calc;
                    rd_state_d = RD_R;
                end
            end
            RD_R: begin
                hp0_rready = i_rd_ready;
                o_rd_valid = hp0_rvalid;
                o_rd_data  = hp0_rdata;
                o_rd_last  = hp0_rlast && rd_final_burst;
                if (hp0_rvalid && i_rd_ready && hp0_rlast) begin
                    rd_addr_d  = rd_addr_q + {24'd0, rd_burst_q, 3'b000};
                    rd_rem_d   = rd_rem_q - {16'd0, rd_burst_q};
                    rd_state_d = rd_final_burst ? RD_IDLE : RD_AR;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end
`else
    logic unused_rd;
    assign unused_rd = ^{i_rd_cmd_data, i_rd_cmd_req, i_rd_ready, hp0_arready,
                         hp0_rdata, hp0_rresp, hp0_rlast, hp0_rvalid};

    assign o_rd_cmd_ack = 1'b0;
    assign o_rd_valid   = 1'b0;
    assign o_rd_last    = 1'b0;
    assign o_rd_data    = '0;
    assign hp0_arvalid  = 1'b0;
    assign hp0_arid     = '0;
    assign hp0_araddr   = '0;
    assign hp0_arlen    = '0;
    assign hp0_arsize   = '0;
    assign hp0_arburst  = '0;
    assign hp0_arprot   = '0;
    assign hp0_arcache  = '0;
    assign hp0_rready   = 1'b0;
`endif

endmodule

// File: tb/tb_datamover_controller.sv
// Directed-plus-random bench: a behavioural AXI slave with memory, a burst-split reference and a byte-masked reference memory.
module tb_datamover_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] i_s2mm_wr_cmd_addr;
    logic [22:0] i_s2mm_wr_cmd_length;
    logic        i_wr_cmd_req, o_wr_cmd_ack;
    logic        i_wr_valid, o_wr_ready, o_write_finish;
    logic [63:0] i_wr_data;
    logic [54:0] i_rd_cmd_data;
    logic        i_rd_cmd_req, o_rd_cmd_ack;
    logic        i_rd_ready, o_rd_valid, o_rd_last;
    logic [63:0] o_rd_data;
    logic        hp0_awready, hp0_awvalid;
    logic [3:0]  hp0_awid, hp0_awlen, hp0_awcache;
    logic [31:0] hp0_awaddr;
    logic [2:0]  hp0_awsize, hp0_awprot;
    logic [1:0]  hp0_awburst;
    logic [63:0] hp0_wdata;
    logic [7:0]  hp0_wstrb;
    logic        hp0_wlast, hp0_wvalid, hp0_wready;
    logic [1:0]  hp0_bresp;
    logic        hp0_bvalid, hp0_bready;
    logic        hp0_arready, hp0_arvalid;
    logic [3:0]  hp0_arid, hp0_arlen, hp0_arcache;
    logic [31:0] hp0_araddr;
    logic [2:0]  hp0_arsize, hp0_arprot;
    logic [1:0]  hp0_arburst;
    logic [63:0] hp0_rdata;
    logic [1:0]  hp0_rresp;
    logic        hp0_rlast, hp0_rvalid, hp0_rready;

    datamover_controller #(.AXI_ID(4'd0), .AXI_CACHE(4'b0011), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .i_s2mm_wr_cmd_addr(i_s2mm_wr_cmd_addr), .i_s2mm_wr_cmd_length(i_s2mm_wr_cmd_length),
        .i_wr_cmd_req(i_wr_cmd_req), .o_wr_cmd_ack(o_wr_cmd_ack),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_write_finish(o_write_finish),
        .i_rd_cmd_data(i_rd_cmd_data), .i_rd_cmd_req(i_rd_cmd_req), .o_rd_cmd_ack(o_rd_cmd_ack),
        .i_rd_ready(i_rd_ready), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last), .o_rd_data(o_rd_data),
        .hp0_awready(hp0_awready), .hp0_awvalid(hp0_awvalid), .hp0_awid(hp0_awid),
        .hp0_awaddr(hp0_awaddr), .hp0_awlen(hp0_awlen), .hp0_awsize(hp0_awsize),
        .hp0_awburst(hp0_awburst), .hp0_awprot(hp0_awprot), .hp0_awcache(hp0_awcache),
        .hp0_wdata(hp0_wdata), .hp0_wstrb(hp0_wstrb), .hp0_wlast(hp0_wlast),
        .hp0_wvalid(hp0_wvalid), .hp0_wready(hp0_wready),
        .hp0_bresp(hp0_bresp), .hp0_bvalid(hp0_bvalid), .hp0_bready(hp0_bready),
        .hp0_arready(hp0_arready), .hp0_arvalid(hp0_arvalid), .hp0_arid(hp0_arid),
        .hp0_araddr(hp0_araddr), .hp0_arlen(hp0_arlen), .hp0_arsize(hp0_arsize),
        .hp0_arburst(hp0_arburst), .hp0_arprot(hp0_arprot), .hp0_arcache(hp0_arcache),
        .hp0_rdata(hp0_rdata), .hp0_rresp(hp0_rresp), .hp0_rlast(hp0_rlast),
        .hp0_rvalid(hp0_rvalid), .hp0_rready(hp0_rready)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
    } wbeat_t;

    int vectors = 0;
    int miscompares = 0;

    bit   [63:0] mem     [int unsigned];
    bit   [63:0] ref_mem [int unsigned];
    logic [63:0] src_q[$];
    logic [63:0] pend_data[$];
    logic [35:0] aw_q[$];
    logic [35:0] ar_q[$];
    wbeat_t      w_q[$];
    logic [64:0] rd_q[$];
    int ack_cnt = 0, fin_cnt = 0, rack_cnt = 0, aw_vld_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [63:0] rd_word(input int unsigned w, input bit from_ref);
        if (from_ref) return ref_mem.exists(w) ? ref_mem[w] : 64'd0;
        return mem.exists(w) ? mem[w] : 64'd0;
    endfunction

    // AXI write slave plus stream source: handshakes judged at negedge, inputs changed 1 after posedge.
    initial begin : wr_side
        int unsigned wptr;
        int          b_pend;
        bit          b_hs;
        bit   [63:0] t;
        wptr = 0; b_pend = 0;
        hp0_awready = 0; hp0_wready = 0; hp0_bvalid = 0; hp0_bresp = 0;
        i_wr_valid = 0; i_wr_data = 0;
        forever begin
            @(negedge clk);
            b_hs = hp0_bvalid && hp0_bready;
            if (o_wr_cmd_ack) ack_cnt++;
            if (o_write_finish) fin_cnt++;
            if (hp0_awvalid) aw_vld_cyc++;
            if (hp0_awvalid && hp0_awready) begin
                aw_q.push_back({hp0_awaddr, hp0_awlen});
                wptr = hp0_awaddr >> 3;
            end
            if (hp0_wvalid && hp0_wready) begin
                w_q.push_back('{hp0_wdata, hp0_wstrb, hp0_wlast});
                t = rd_word(wptr, 1'b0);
                for (int b = 0; b < 8; b++)
                    if (hp0_wstrb[b]) t[b*8 +: 8] = hp0_wdata[b*8 +: 8];
                mem[wptr] = t;
                wptr++;
                if (hp0_wlast) b_pend++;
                if (src_q.size() > 0) void'(src_q.pop_front());
            end
            @(posedge clk); #1;
            hp0_awready = ($urandom_range(0, 3) != 0);
            hp0_wready  = ($urandom_range(0, 3) != 0);
            if (src_q.size() > 0) begin
                i_wr_valid = ($urandom_range(0, 3) != 0);
                i_wr_data  = src_q[0];
            end else begin
                i_wr_valid = 0;
                i_wr_data  = 0;
            end
            if (b_hs) begin
                hp0_bvalid = 0;
                b_pend--;
            end else if (!hp0_bvalid && b_pend > 0 && $urandom_range(0, 1) == 1) begin
                hp0_bvalid = 1;
                hp0_bresp  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            end
        end
    end

    // AXI read slave serving from the same memory, plus the downstream consumer.
    initial begin : rd_side
        logic [35:0] rb[$];
        int          rbeat;
        bit          r_hs;
        int unsigned w;
        rbeat = 0;
        hp0_arready = 0; hp0_rvalid = 0; hp0_rdata = 0; hp0_rlast = 0; hp0_rresp = 0;
        i_rd_ready = 0;
        forever begin
            @(negedge clk);
            r_hs = hp0_rvalid && hp0_rready;
            if (o_rd_cmd_ack) rack_cnt++;
            if (hp0_arvalid && hp0_arready) begin
                ar_q.push_back({hp0_araddr, hp0_arlen});
                rb.push_back({hp0_araddr, hp0_arlen});
            end
            if (o_rd_valid && i_rd_ready) rd_q.push_back({o_rd_last, o_rd_data});
            if (r_hs && rb.size() > 0) begin
                if (rbeat == int'(rb[0][3:0])) begin
                    void'(rb.pop_front());
                    rbeat = 0;
                end else begin
                    rbeat++;
                end
            end
            @(posedge clk); #1;
            hp0_arready = ($urandom_range(0, 2) != 0);
            i_rd_ready  = ($urandom_range(0, 1) == 1);
            if (!(hp0_rvalid && !r_hs)) begin
                if (rb.size() > 0 && $urandom_range(0, 3) != 0) begin
                    w          = (rb[0][35:4] >> 3) + rbeat;
                    hp0_rvalid = 1;
                    hp0_rdata  = rd_word(w, 1'b0);
                    hp0_rlast  = (rbeat == int'(rb[0][3:0]));
                end else begin
                    hp0_rvalid = 0;
                    hp0_rdata  = 0;
                    hp0_rlast  = 0;
                end
            end
        end
    end

    // Reference burst split: min(remaining, 16, beats to the 4 KB boundary).
    task automatic split(input int addr, input int beats, output int ea[$], output int en[$]);
        int a, rem, n;
        a = addr & ~7; rem = beats;
        ea.delete(); en.delete();
        while (rem > 0) begin
            n = rem;
            if (n > 16) n = 16;
            if (n > (4096 - a % 4096) / 8) n = (4096 - a % 4096) / 8;
            ea.push_back(a); en.push_back(n);
            a += n * 8; rem -= n;
        end
    endtask

    task automatic do_write(input string tag, input int addr, input int len, input int hold);
        int          beats, cyc, k, e;
        int          ea[$], en[$];
        logic [63:0] data[$];
        logic [7:0]  es;
        logic [63:0] m;
        bit          exp_last[$];
        int unsigned w;
        beats = (len + 7) / 8;
        ack_cnt = 0; fin_cnt = 0; aw_vld_cyc = 0;
        aw_q.delete(); w_q.delete();
        for (int i = 0; i < beats; i++)
            data.push_back(i < pend_data.size() ? pend_data[i] : {$urandom, $urandom});
        pend_data.delete();
        split(addr, beats, ea, en);
        foreach (en[i]) for (int j = 0; j < en[i]; j++) exp_last.push_back(j == en[i] - 1);
        foreach (data[i]) src_q.push_back(data[i]);
        i_s2mm_wr_cmd_addr = addr; i_s2mm_wr_cmd_length = 23'(len); i_wr_cmd_req = 1;
        cyc = 0;
        while (ack_cnt == 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check({tag, " ack_timeout"}, cyc < 100, 1);
        repeat (hold) begin @(posedge clk); #1; end
        i_wr_cmd_req = 0;
        cyc = 0;
        while (fin_cnt == 0 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check({tag, " finish_timeout"}, cyc < 3000, 1);
        repeat (6) begin @(posedge clk); #1; end
        check({tag, " ack_count"}, ack_cnt, 1);
        check({tag, " finish_count"}, fin_cnt, 1);
        check({tag, " awvalid_seen"}, aw_vld_cyc > 0, beats > 0);
        check({tag, " aw_count"}, aw_q.size(), ea.size());
        foreach (ea[i]) if (i < aw_q.size()) begin
            check({tag, " awaddr"}, aw_q[i][35:4], ea[i]);
            check({tag, " awlen"}, aw_q[i][3:0], en[i] - 1);
        end
        check({tag, " w_beats"}, w_q.size(), beats);
        k = 0;
        for (int i = 0; i < beats; i++) begin
            e  = len % 8;
            es = (i == beats - 1 && e != 0) ? 8'((1 << e) - 1) : 8'hFF;
            for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{es[b]}};
            w = (addr >> 3) + i;
            ref_mem[w] = (rd_word(w, 1'b1) & ~m) | (data[i] & m);
            if (i < w_q.size()) begin
                check({tag, " wdata"}, w_q[i].d, data[i]);
                check({tag, " wstrb"}, w_q[i].s, es);
                check({tag, " wlast"}, w_q[i].l, exp_last[i]);
            end
            check({tag, " mem"}, rd_word(w, 1'b0), ref_mem[w]);
            k++;
        end
    endtask

`ifdef DATAMOVER_RD_PATH_EN
    task automatic do_read(input string tag, input int addr, input int len);
        int ea[$], en[$];
        int beats, cyc;
        beats = (len + 7) / 8;
        rack_cnt = 0; ar_q.delete(); rd_q.delete();
        split(addr, beats, ea, en);
        i_rd_cmd_data = {23'(len), 32'(addr)}; i_rd_cmd_req = 1;
        cyc = 0;
        while (rack_cnt == 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check({tag, " rack_timeout"}, cyc < 100, 1);
        i_rd_cmd_req = 0;
        cyc = 0;
        while (rd_q.size() < beats && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check({tag, " rd_timeout"}, cyc < 3000, 1);
        repeat (6) begin @(posedge clk); #1; end
        check({tag, " rack_count"}, rack_cnt, 1);
        check({tag, " ar_count"}, ar_q.size(), ea.size());
        foreach (ea[i]) if (i < ar_q.size()) begin
            check({tag, " araddr"}, ar_q[i][35:4], ea[i]);
            check({tag, " arlen"}, ar_q[i][3:0], en[i] - 1);
        end
        check({tag, " rd_beats"}, rd_q.size(), beats);
        for (int i = 0; i < beats; i++) if (i < rd_q.size()) begin
            check({tag, " rdata"}, rd_q[i][63:0], rd_word((addr >> 3) + i, 1'b1));
            check({tag, " rlast"}, rd_q[i][64], i == beats - 1);
        end
    endtask
`endif

    initial begin : main
        int a, l;
        rst = 1;
        i_s2mm_wr_cmd_addr = 0; i_s2mm_wr_cmd_length = 0; i_wr_cmd_req = 0;
        i_rd_cmd_data = 0; i_rd_cmd_req = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst wr_cmd_ack", o_wr_cmd_ack, 0);
        check("rst write_finish", o_write_finish, 0);
        check("rst wr_ready", o_wr_ready, 0);
        check("rst awvalid", hp0_awvalid, 0);
        check("rst awaddr", hp0_awaddr, 0);
        check("rst awlen", hp0_awlen, 0);
        check("rst wvalid", hp0_wvalid, 0);
        check("rst wlast", hp0_wlast, 0);
        check("rst bready", hp0_bready, 0);
        check("rst rd_cmd_ack", o_rd_cmd_ack, 0);
        check("rst rd_valid", o_rd_valid, 0);
        check("rst rd_last", o_rd_last, 0);
        check("rst arvalid", hp0_arvalid, 0);
        check("rst rready", hp0_rready, 0);
        check("rst araddr", hp0_araddr, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (2) begin @(posedge clk); #1; end

        pend_data.push_back(64'h0102030405060708);
        pend_data.push_back(64'h0203040506070809);
        do_write("w16", 0, 16, 0);
        do_write("w200", 0, 200, 0);
        do_write("w4k", 'hFF8, 32, 0);
        do_write("w12", 'h200, 12, 0);
        do_write("w0", 'h300, 0, 0);
        do_write("hold", 'h400, 64, 3);
        for (int i = 0; i < 4; i++) begin
            a = int'($urandom_range(0, 'h2FFF));
            l = int'($urandom_range(1, 300));
            do_write("wrand", a, l, 0);
        end
`ifdef DATAMOVER_RD_PATH_EN
        do_read("r200", 0, 200);
        do_read("r4k", 'hFF8, 40);
        do_read("rrand", int'($urandom_range(0, 'h2FFF)), int'($urandom_range(1, 300)));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
